// File: rtl/mem_wb_stage.sv
// MEM pipeline stage plus MEM/WB register.
// Resolves branches, runs loads/stores against a multi-cycle internal data memory,
// stalls upstream while an access is in flight and registers results for write-back.
module mem_wb_stage #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        em_mem2reg,
  input  logic        em_ctrl_regwr,
  input  logic        em_memrd,
  input  logic        em_memwr,
  input  logic        em_branch,
  input  logic [11:0] em_pc_out,
  input  logic        em_zero,
  input  logic [63:0] em_alu_out,
  input  logic [63:0] em_read_data2,
  input  logic [5:0]  em_wr_reg,
  output logic        mem_stall,
  output logic        pc_src,
  output logic [11:0] branch_target,
  output logic        mw_mem2reg,
  output logic        mw_ctrl_regwr,
  output logic [63:0] mw_read_data,
  output logic [63:0] mw_alu_out,
  output logic [5:0]  mw_wr_reg
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [63:0]       r_mem [Depth];

  logic              w_req;
  logic [ADDR_W-1:0] w_idx;
  logic [63:0]       w_rd_data;
  logic              w_unused_bits;

  // Byte address -> word index; sub-word and out-of-range bits are dropped so indices wrap.
  assign w_idx         = em_alu_out[ADDR_W+2:3];
  assign w_unused_bits = ^{em_alu_out[63:ADDR_W+3], em_alu_out[2:0]};
  assign w_req         = em_memrd | em_memwr;
  assign w_rd_data     = r_mem[w_idx];

  // Stall covers the request cycle and every busy cycle; forced low while in reset.
  assign mem_stall     = ~rst & (((r_state == StIdle) & w_req) | (r_state == StBusy));
  assign pc_src        = em_branch & em_zero & ~mem_stall;
  assign branch_target = em_pc_out;

  // Access sequencer: IDLE -> BUSY (MEM_LAT-1 cycles) -> DONE -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_req) begin
            if (MEM_LAT == 1) begin
              r_state <= StDone;
            end else begin
              r_state <= StBusy;
              r_cnt   <= CntW'(1);
            end
          end
        end
        StBusy: begin
          if (r_cnt == CntW'(MEM_LAT - 1)) begin
            r_state <= StDone;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Store commits on the edge that ends DONE; a reset before that edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == StDone) && em_memwr) begin
      r_mem[w_idx] <= em_read_data2;
    end
  end

  // MEM/WB register: capture when not stalled, insert a bubble while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_mem2reg    <= 1'b0;
      mw_ctrl_regwr <= 1'b0;
      mw_read_data  <= '0;
      mw_alu_out    <= '0;
      mw_wr_reg     <= '0;
    end else if (mem_stall) begin
      mw_mem2reg    <= 1'b0;
      mw_ctrl_regwr <= 1'b0;
    end else begin
      mw_mem2reg    <= em_mem2reg;
      mw_ctrl_regwr <= em_ctrl_regwr;
      mw_alu_out    <= em_alu_out;
      mw_wr_reg     <= em_wr_reg;
      // Read happens at the same edge as a store commit, so load+store sees the old word.
      if (em_memrd) begin
        mw_read_data <= w_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vectors, expected write-backs queued
// by the driver and checked by an independent monitor whenever mw_ctrl_regwr fires.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        em_mem2reg;
  logic        em_ctrl_regwr;
  logic        em_memrd;
  logic        em_memwr;
  logic        em_branch;
  logic [11:0] em_pc_out;
  logic        em_zero;
  logic [63:0] em_alu_out;
  logic [63:0] em_read_data2;
  logic [5:0]  em_wr_reg;
  logic        mem_stall;
  logic        pc_src;
  logic [11:0] branch_target;
  logic        mw_mem2reg;
  logic        mw_ctrl_regwr;
  logic [63:0] mw_read_data;
  logic [63:0] mw_alu_out;
  logic [5:0]  mw_wr_reg;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [5:0]  wr;
    logic [63:0] alu;
    logic [63:0] rd;
    logic        m2r;
    logic        chk_rd;
  } exp_t;

  exp_t exp_q[$];

  mem_wb_stage #(
    .ADDR_W  (8),
    .MEM_LAT (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .em_mem2reg    (em_mem2reg),
    .em_ctrl_regwr (em_ctrl_regwr),
    .em_memrd      (em_memrd),
    .em_memwr      (em_memwr),
    .em_branch     (em_branch),
    .em_pc_out     (em_pc_out),
    .em_zero       (em_zero),
    .em_alu_out    (em_alu_out),
    .em_read_data2 (em_read_data2),
    .em_wr_reg     (em_wr_reg),
    .mem_stall     (mem_stall),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .mw_mem2reg    (mw_mem2reg),
    .mw_ctrl_regwr (mw_ctrl_regwr),
    .mw_read_data  (mw_read_data),
    .mw_alu_out    (mw_alu_out),
    .mw_wr_reg     (mw_wr_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write-back pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && mw_ctrl_regwr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_wb: got wr_reg %0d with empty queue expected none", mw_wr_reg);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_wr_reg", 64'(mw_wr_reg), 64'(e.wr));
        chk("wb_alu_out", mw_alu_out, e.alu);
        chk("wb_mem2reg", 64'(mw_mem2reg), 64'(e.m2r));
        if (e.chk_rd) chk("wb_read_data", mw_read_data, e.rd);
      end
    end
  end

  // Issue one instruction (called at posedge+1); returns at posedge+1 after it retires.
  task automatic do_instr(input logic rd, input logic wr, input logic m2r, input logic regwr,
                          input logic [63:0] alu, input logic [63:0] data,
                          input logic [5:0] wreg, input logic [63:0] rd_exp,
                          input int exp_stalls);
    int stalls;
    bit done;
    em_memrd      = rd;
    em_memwr      = wr;
    em_mem2reg    = m2r;
    em_ctrl_regwr = regwr;
    em_alu_out    = alu;
    em_read_data2 = data;
    em_wr_reg     = wreg;
    em_branch     = 1'b0;
    em_zero       = 1'b0;
    if (regwr) exp_q.push_back('{wr: wreg, alu: alu, rd: rd_exp, m2r: m2r, chk_rd: rd});
    stalls = 0;
    done   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!mem_stall) begin
        done = 1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL stall_timeout: got stall stuck high expected release");
    end
    chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
    @(posedge clk);
    #1;
    em_memrd      = 1'b0;
    em_memwr      = 1'b0;
    em_ctrl_regwr = 1'b0;
    em_mem2reg    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    em_mem2reg = 0; em_ctrl_regwr = 0; em_memrd = 0; em_memwr = 0; em_branch = 0;
    em_pc_out = '0; em_zero = 0; em_alu_out = '0; em_read_data2 = '0; em_wr_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_pc_src", 64'(pc_src), 64'd0);
    chk("rst_mw_regwr", 64'(mw_ctrl_regwr), 64'd0);
    chk("rst_mw_read_data", mw_read_data, 64'd0);
    chk("rst_mw_alu_out", mw_alu_out, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: store then load at 0x10
    do_instr(0, 1, 0, 0, 64'h10, 64'hDEADBEEF, 6'd0, 64'h0, 2);
    do_instr(1, 0, 1, 1, 64'h10, 64'h0, 6'd5, 64'hDEADBEEF, 2);

    // 2: plain ALU op, no stall
    do_instr(0, 0, 0, 1, 64'h55, 64'h0, 6'd3, 64'h0, 0);

    // 3: branch resolution, plus masking by a pending memory request
    em_branch = 1; em_zero = 1; em_pc_out = 12'h0A4;
    #1;
    chk("pc_src_taken", 64'(pc_src), 64'd1);
    chk("branch_target", 64'(branch_target), 64'h0A4);
    em_zero = 0;
    #1;
    chk("pc_src_not_zero", 64'(pc_src), 64'd0);
    em_zero = 1; em_memrd = 1;
    #1;
    chk("pc_src_stalled", 64'(pc_src), 64'd0);
    em_memrd = 0; em_branch = 0; em_zero = 0;
    @(posedge clk);
    #1;

    // 4: index wrap (0x808 -> 1) and ignored low bits (0x00F -> 1)
    do_instr(0, 1, 0, 0, 64'h808, 64'h1234, 6'd0, 64'h0, 2);
    do_instr(1, 0, 1, 1, 64'h00F, 64'h0, 6'd7, 64'h1234, 2);

    // 5: load+store returns pre-store value
    do_instr(0, 1, 0, 0, 64'h20, 64'h1, 6'd0, 64'h0, 2);
    do_instr(1, 1, 1, 1, 64'h20, 64'h2, 6'd8, 64'h1, 2);
    do_instr(1, 0, 1, 1, 64'h20, 64'h0, 6'd10, 64'h2, 2);

    // 6: reset during BUSY aborts the store
    do_instr(0, 1, 0, 0, 64'h40, 64'h77, 6'd0, 64'h0, 2);
    em_memwr = 1; em_alu_out = 64'h40; em_read_data2 = 64'h99;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_stall", 64'(mem_stall), 64'd0);
    chk("abort_mw_regwr", 64'(mw_ctrl_regwr), 64'd0);
    chk("abort_mw_mem2reg", 64'(mw_mem2reg), 64'd0);
    chk("abort_mw_read_data", mw_read_data, 64'd0);
    chk("abort_mw_alu_out", mw_alu_out, 64'd0);
    chk("abort_mw_wr_reg", 64'(mw_wr_reg), 64'd0);
    em_memwr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_instr(1, 0, 1, 1, 64'h40, 64'h0, 6'd9, 64'h77, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
